ram_4k8_2k16: RTL and testbench
===============================

Name: ram_4k8_2k16

Overview:
- Dual-port synchronous RAM holding 4096 bytes.
- Port A is an 8-bit read/write CPU-side port addressing 4K x 8.
- Port B is a 16-bit read-only video-side port addressing the same storage as 2K x 16.
- Sits between the v65C02 bus and the VGA text/pixel fetch logic. Both ports run on a single clock.

Parameters:
- INIT_FILE, "" (empty), optional $readmemh image loaded at elaboration. Empty means all bytes are 8'h00.

Ports:
- clk_i  input  1  system clock; all state changes on its rising edge
- rst_n_i  input  1  asynchronous active-low reset; clears output registers only
- ena_i  input  1  port A enable
- wea_i  input  1  port A write enable; qualified by ena_i
- addra_i  input  12  port A byte address
- dia_i  input  8  port A write data
- doa_o  output  8  port A registered read data
- enb_i  input  1  port B enable
- addrb_i  input  11  port B word address
- dob_o  output  16  port B registered read data

Behaviour:
- Storage is 4096 x 8. Byte address n is word (n>>1), lane n[0].
- Port B word k = {byte[2k+1], byte[2k]}, little-endian. dob_o[7:0] is the even byte, dob_o[15:8] is the odd byte.
- Reset: while rst_n_i=0, doa_o=8'h00 and dob_o=16'h0000, asynchronously. Memory contents are not altered by reset. Writes are ignored while in reset.
- Port A write: at a rising edge with ena_i=1 and wea_i=1, byte[addra_i] <= dia_i.
- Port A read: at a rising edge with ena_i=1, doa_o <= byte[addra_i]. This gives 1-cycle latency.
- Port A write mode is read-first. On a write cycle doa_o gets the previous contents of addra_i; the new data is visible on the next read.
- Port B read: at a rising edge with enb_i=1, dob_o <= word[addrb_i]. This gives 1-cycle latency.
- With ena_i=0, doa_o holds its last value and no write occurs. With enb_i=0, dob_o holds its last value. wea_i is ignored when ena_i=0.
- Collision: port A writes a byte of word k in the same cycle port B reads word k. Port B returns the old contents; the new byte is visible from the next cycle.
- Ports are fully independent. Simultaneous A and B accesses are allowed every cycle with no stall and no handshake.
- No address wrap logic is needed. The full address ranges map exactly onto the storage.
- Reset deasserted mid-operation: the first rising edge after deassertion performs normal accesses.
- Implementation must infer block RAM: synchronous read and no reset on the array.

Decomposition:
- No shared package needed. Local constants: DEPTH_A=4096, DEPTH_B=2048.
- The natural split is two instances of sub-module ram_2k8_bank, each a 2K x 8 single-write/dual-read bank.
  - Even bank stores bytes with addra_i[0]=0; odd bank stores addra_i[0]=1.
  - Bank write enable = ena_i & wea_i & lane match. Bank address for port A = addra_i[11:1]; for port B = addrb_i.
- doa_o is selected from the bank indicated by addra_i[0], registered with the read.
- dob_o = {odd bank read, even bank read}.
- Output registers and the reset clear live in the top level or the banks. Reset applies to output registers only.

Test Plan:
- Reset: assert rst_n_i=0 with prior nonzero outputs -> doa_o=8'h00 and dob_o=16'h0000 immediately, without a clock edge.
- Byte write/read: write 8'h01 @A 12'h000 and 8'h02 @A 12'h001, then read A 000 and A 001 -> doa_o=8'h01 then 8'h02, each one cycle after its address.
- Word view: after the above, read B 11'h000 -> dob_o=16'h0201 one cycle later. Write 8'hAA @A 12'hFFE and 8'h55 @A 12'hFFF, read B 11'h7FF -> 16'h55AA.
- Hold on disable: after reads, drop ena_i/enb_i and change addresses -> doa_o stays 8'h02 and dob_o stays 16'h0201.
- Read-first and collision: A 12'h000 holds 8'h01. Write 8'h77 @A 12'h000 while reading B 11'h000 -> that edge gives doa_o=8'h01 and dob_o=16'h0201. Next reads give 8'h77 and 16'h0277.
- wea_i without ena_i: ena_i=0, wea_i=1, dia_i=8'hFF @12'h001 -> subsequent read of A 12'h001 still returns 8'h02.

Source files
------------

// File: rtl/ram_4k8_2k16_pkg.sv
// Geometry constants shared by the 4K x 8 / 2K x 16 dual-view RAM and its banks.
package ram_4k8_2k16_pkg;
    localparam int DEPTH_A = 4096;
    localparam int DEPTH_B = 2048;
    localparam int AW_A    = 12;
    localparam int AW_B    = 11;
endpackage

// File: rtl/ram_4k8_2k16_bank.sv
// One byte lane of the shared RAM: 2K x 8, a single write port and two registered read ports.
module ram_2k8_bank
    import ram_4k8_2k16_pkg::*;
#(
    parameter string INIT_FILE = "",
    parameter int    LANE      = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_a,
    input  logic            we_a,
    input  logic [AW_B-1:0] addr_a,
    input  logic [7:0]      din_a,
    output logic [7:0]      q_a,
    input  logic            en_b,
    input  logic [AW_B-1:0] addr_b,
    output logic [7:0]      q_b
);
    logic [7:0] mem [DEPTH_B];

    initial begin
        for (int i = 0; i < DEPTH_B; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (we_a && rst_n) mem[addr_a] <= din_a;
    end

    // Reads sample the array before this edge's write lands: read-first on A, old data on B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a <= 8'h00;
            q_b <= 8'h00;
        end else begin
            if (en_a) q_a <= mem[addr_a];
            if (en_b) q_b <= mem[addr_b];
        end
    end
endmodule

// File: rtl/ram_4k8_2k16.sv
// 4096-byte dual-port RAM: 8-bit R/W CPU port, 16-bit read-only little-endian video port.
module ram_4k8_2k16
    import ram_4k8_2k16_pkg::*;
#(
    parameter string INIT_FILE = ""
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            ena_i,
    input  logic            wea_i,
    input  logic [AW_A-1:0] addra_i,
    input  logic [7:0]      dia_i,
    output logic [7:0]      doa_o,
    input  logic            enb_i,
    input  logic [AW_B-1:0] addrb_i,
    output logic [15:0]     dob_o
);
    logic [1:0][7:0] qa;
    logic [1:0][7:0] qb;
    logic            lane_q;

    // Bank 0 holds even bytes, bank 1 odd bytes; both read on every A access.
    for (genvar g = 0; g < 2; g++) begin : g_bank
        ram_2k8_bank #(
            .INIT_FILE (INIT_FILE),
            .LANE      (g)
        ) u_bank (
            .clk    (clk_i),
            .rst_n  (rst_n_i),
            .en_a   (ena_i),
            .we_a   (ena_i && wea_i && (addra_i[0] == 1'(g))),
            .addr_a (addra_i[AW_A-1:1]),
            .din_a  (dia_i),
            .q_a    (qa[g]),
            .en_b   (enb_i),
            .addr_b (addrb_i),
            .q_b    (qb[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)   lane_q <= 1'b0;
        else if (ena_i) lane_q <= addra_i[0];
    end

    assign doa_o = qa[lane_q];
    assign dob_o = {qb[1], qb[0]};
endmodule

// File: tb/tb_ram_4k8_2k16.sv
// Directed scoreboard bench for ram_4k8_2k16: expected outputs queued per cycle, checked by a monitor.
module tb_ram_4k8_2k16;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        ena_i, wea_i, enb_i;
    logic [11:0] addra_i;
    logic [7:0]  dia_i;
    logic [10:0] addrb_i;
    logic [7:0]  doa_o;
    logic [15:0] dob_o;

    typedef struct {
        bit          chk;
        logic [15:0] exp;
        int          step;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   m_chk = 0, m_pass = 0;
    int   r_chk = 0, r_pass = 0;
    int   step = 0;

    ram_4k8_2k16 #(.INIT_FILE("")) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .ena_i   (ena_i),
        .wea_i   (wea_i),
        .addra_i (addra_i),
        .dia_i   (dia_i),
        .doa_o   (doa_o),
        .enb_i   (enb_i),
        .addrb_i (addrb_i),
        .dob_o   (dob_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one cycle just after a falling edge and queue what the outputs must show
    // at the falling edge following the next rising edge.
    task automatic cyc(input bit ea_, input bit wa, input logic [11:0] aa, input logic [7:0] d,
                       input bit eb_, input logic [10:0] ab,
                       input bit ca, input logic [7:0] xa, input bit cb, input logic [15:0] xb);
        @(negedge clk_i); #1;
        ena_i = ea_; wea_i = wa; addra_i = aa; dia_i = d;
        enb_i = eb_; addrb_i = ab;
        step++;
        qa.push_back('{chk: ca, exp: {8'h00, xa}, step: step});
        qb.push_back('{chk: cb, exp: xb, step: step});
    endtask

    always @(negedge clk_i) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            if (ea.chk) begin
                m_chk++;
                if (doa_o !== ea.exp[7:0])
                    $display("FAIL doa step%0d: got %h expected %h", ea.step, doa_o, ea.exp[7:0]);
                else m_pass++;
            end
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            if (eb.chk) begin
                m_chk++;
                if (dob_o !== eb.exp)
                    $display("FAIL dob step%0d: got %h expected %h", eb.step, dob_o, eb.exp);
                else m_pass++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n_i = 1'b0;
        ena_i = 0; wea_i = 0; enb_i = 0; addra_i = '0; dia_i = '0; addrb_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        r_chk++;
        if (doa_o !== 8'h00 || dob_o !== 16'h0000)
            $display("FAIL reset_init: got doa=%h dob=%h expected 00/0000", doa_o, dob_o);
        else r_pass++;
        @(negedge clk_i); #1 rst_n_i = 1'b1;

        //   en we addrA   dA     en addrB   chkA expA   chkB expB
        cyc(1, 1, 12'h000, 8'h01, 0, 11'h000, 0, 8'h00, 0, 16'h0000);
        cyc(1, 1, 12'h001, 8'h02, 0, 11'h000, 0, 8'h00, 0, 16'h0000);
        cyc(1, 0, 12'h000, 8'h00, 1, 11'h000, 1, 8'h01, 1, 16'h0201);
        cyc(1, 0, 12'h001, 8'h00, 0, 11'h000, 1, 8'h02, 1, 16'h0201);
        // Both ports disabled, addresses moved: outputs hold.
        cyc(0, 0, 12'hFFF, 8'h00, 0, 11'h7FF, 1, 8'h02, 1, 16'h0201);
        // wea without ena must not write.
        cyc(0, 1, 12'h001, 8'hFF, 0, 11'h7FF, 1, 8'h02, 1, 16'h0201);
        cyc(1, 1, 12'hFFE, 8'hAA, 0, 11'h7FF, 1, 8'h00, 1, 16'h0201);
        // Top-address write collides with B read of word 7FF: B sees old odd byte.
        cyc(1, 1, 12'hFFF, 8'h55, 1, 11'h7FF, 1, 8'h00, 1, 16'h00AA);
        cyc(1, 0, 12'hFFF, 8'h00, 1, 11'h7FF, 1, 8'h55, 1, 16'h55AA);
        // Read-first on A plus collision on B for word 0.
        cyc(1, 1, 12'h000, 8'h77, 1, 11'h000, 1, 8'h01, 1, 16'h0201);
        cyc(1, 0, 12'h000, 8'h00, 1, 11'h000, 1, 8'h77, 1, 16'h0277);
        cyc(1, 0, 12'h001, 8'h00, 0, 11'h000, 1, 8'h02, 1, 16'h0277);
        cyc(1, 0, 12'hFFE, 8'h00, 0, 11'h000, 1, 8'hAA, 1, 16'h0277);
        repeat (2) @(negedge clk_i);

        // Asynchronous clear with nonzero outputs, checked before any edge.
        #2 rst_n_i = 1'b0;
        #1;
        r_chk++;
        if (doa_o !== 8'h00 || dob_o !== 16'h0000)
            $display("FAIL reset_async: got doa=%h dob=%h expected 00/0000", doa_o, dob_o);
        else r_pass++;
        // Write during reset is ignored; outputs stay cleared.
        cyc(1, 1, 12'h000, 8'h33, 1, 11'h000, 1, 8'h00, 1, 16'h0000);
        @(negedge clk_i); #1 rst_n_i = 1'b1;
        ena_i = 0; wea_i = 0; enb_i = 0;
        cyc(1, 0, 12'h000, 8'h00, 1, 11'h000, 1, 8'h77, 1, 16'h0277);
        cyc(1, 0, 12'hFFF, 8'h00, 1, 11'h7FF, 1, 8'h55, 1, 16'h55AA);
        @(negedge clk_i); #1 ena_i = 0; enb_i = 0;
        repeat (3) @(negedge clk_i);
        #1;
        $display("%0d/%0d checks passed", m_pass + r_pass, m_chk + r_chk);
        $finish;
    end
endmodule
